// File: rtl/m_sequence_burst_ctrl.sv
// -----------------------------------------------------------------------------
// m_sequence_burst_ctrl
//
// Purpose:
//   Runs a Fibonacci m-sequence LFSR in command-driven bursts. Each accepted
//   command loads a seed and then emits exactly cmd_len chips on a valid/ready
//   stream. Chips where the register has returned to the burst seed are
//   flagged with period_start. An active burst can be aborted.
//
// Parameters:
//   WIDTH        LFSR register width (2..32)
//   TAPS         feedback mask, fb = ^(state & TAPS)
//   DEFAULT_SEED register value after reset; also the substitute for an
//                all-zero seed when the zero guard is built in
//   LEN_W        width of the burst-length field
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   cmd_valid      in   command present
//   cmd_ready      out  command accepted when cmd_valid & cmd_ready
//   cmd_seed       in   [WIDTH] seed loaded on accept
//   cmd_len        in   [LEN_W] number of chips to emit (0 is legal)
//   cmd_abort      in   terminates an active burst (ignored outside RUN)
//   out_valid      out  chip available
//   out_ready      in   consumer accepts chip
//   out_bit        out  chip value, lfsr_state[0]
//   out_last       out  qualifies the final chip of a burst
//   period_start   out  qualifies a chip whose state equals the latched seed
//   busy           out  controller not idle
//   done           out  one-cycle pulse after a normal completion
//   lfsr_state     out  [WIDTH] current LFSR register
//   err_zero_seed  out  one-cycle pulse when a zero seed was substituted
//
// Build option:
//   M_SEQ_ZERO_GUARD_EN  when defined, an all-zero cmd_seed is replaced by
//                        DEFAULT_SEED and err_zero_seed pulses in the cycle
//                        after accept. When undefined, err_zero_seed is 0 and
//                        a zero seed is loaded as-is (the LFSR then locks up
//                        and emits constant 0).
// -----------------------------------------------------------------------------
module m_sequence_burst_ctrl #(
   parameter int               WIDTH        = 4,
   parameter logic [WIDTH-1:0] TAPS         = 4'b0011,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = 4'b0011,
   parameter int               LEN_W        = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_seed,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             cmd_abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic             out_last,
   output logic             period_start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lfsr_state,
   output logic             err_zero_seed
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_reg, state_next;
   logic [WIDTH-1:0] lfsr_reg,  lfsr_next;
   logic [WIDTH-1:0] seed_reg,  seed_next;
   logic [LEN_W-1:0] count_reg, count_next;

   logic             accept;
   logic             handshake;
   logic             count_is_one;
   logic [WIDTH-1:0] load_seed;
   logic [WIDTH-1:0] tap_bits;
   logic             feedback;
   logic [WIDTH-1:0] lfsr_stepped;

   // ------------------------------------------------------------------------
   // Feedback network: AND each register bit with its tap, XOR-reduce.
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
         assign tap_bits[gi] = lfsr_reg[gi] & TAPS[gi];
      end
   endgenerate

   assign feedback     = ^tap_bits;
   // Fibonacci shift toward bit 0; the new bit enters at the MSB.
   assign lfsr_stepped = {feedback, lfsr_reg[WIDTH-1:1]};

   // ------------------------------------------------------------------------
   // Seed selection (optional zero guard)
   // ------------------------------------------------------------------------
`ifdef M_SEQ_ZERO_GUARD_EN
   logic seed_is_zero;
   logic err_reg;

   assign seed_is_zero = (cmd_seed == '0);
   // An all-zero seed would lock the LFSR; swap in the default instead.
   assign load_seed    = seed_is_zero ? DEFAULT_SEED : cmd_seed;

   always_ff @(posedge clock) begin
      if (reset) begin
         err_reg <= 1'b0;
      end else begin
         err_reg <= accept && seed_is_zero;
      end
   end

   assign err_zero_seed = err_reg;
`else
   assign load_seed     = cmd_seed;
   assign err_zero_seed = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Handshakes and decoded outputs
   // ------------------------------------------------------------------------
   assign cmd_ready    = (state_reg == ST_IDLE);
   assign out_valid    = (state_reg == ST_RUN);
   assign busy         = (state_reg != ST_IDLE);
   assign done         = (state_reg == ST_DONE);

   assign accept       = cmd_valid && cmd_ready;
   assign handshake    = out_valid && out_ready;
   assign count_is_one = (count_reg == LEN_W'(1));

   assign out_bit      = lfsr_reg[0];
   assign out_last     = out_valid && count_is_one;
   // The first chip always matches because lfsr was loaded with the seed;
   // later matches mark each return to the start of the period.
   assign period_start = out_valid && (lfsr_reg == seed_reg);
   assign lfsr_state   = lfsr_reg;

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      lfsr_next  = lfsr_reg;
      seed_next  = seed_reg;
      count_next = count_reg;

      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               seed_next  = load_seed;
               lfsr_next  = load_seed;
               count_next = cmd_len;
               state_next = (cmd_len != '0) ? ST_RUN : ST_DONE;
            end
         end

         ST_RUN: begin
            // A chip taken in the same cycle as an abort still counts, so
            // the step happens regardless of cmd_abort.
            if (handshake) begin
               lfsr_next  = lfsr_stepped;
               count_next = count_reg - LEN_W'(1);
            end
            // Abort wins over completion on the final chip: no done pulse.
            if (cmd_abort) begin
               state_next = ST_IDLE;
            end else if (handshake && count_is_one) begin
               state_next = ST_DONE;
            end
         end

         ST_DONE: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         lfsr_reg  <= DEFAULT_SEED;
         seed_reg  <= DEFAULT_SEED;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         lfsr_reg  <= lfsr_next;
         seed_reg  <= seed_next;
         count_reg <= count_next;
      end
   end

endmodule
